// File: rtl/idct_macu_if.sv
// idct_macu_if: term-in / result-out bus of the IDCT multiply-accumulate unit.
//
// Handshake: both channels are strict valid/ready. A transfer happens on the
// rising edge where valid & ready are both high. Once valid is raised, the
// source holds valid and its payload unchanged until that transfer. The
// valid signal never depends on ready, and ready may depend on valid.
interface idct_macu_if #(
  parameter int DIN_W = 12,
  parameter int CW    = 12,
  parameter int OUT_W = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DIN_W-1:0] in_data;
  logic signed [CW-1:0]    in_coef;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  // The term source and result sink (bench or parent block).
  modport master (
    output in_valid, in_data, in_coef, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The MAC unit itself.
  modport slave (
    input  in_valid, in_data, in_coef, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/idct_macu.sv
// idct_macu: inverse-DCT multiply-accumulate unit.
// Stage 1 registers coefficient*constant; stage 2 accumulates NTERMS products,
// rounds (half-LSB add, arithmetic shift by FRAC) and presents one sample.
// Optional macro IDCT_MACU_SAT_EN: clamp the shifted result to the OUT_W
// signed range instead of wrapping to its low OUT_W bits.
module idct_macu #(
  parameter int DIN_W  = 12,
  parameter int CW     = 12,
  parameter int FRAC   = 11,
  parameter int NTERMS = 8,
  parameter int ACC_W  = 27,
  parameter int OUT_W  = 12
) (
  input  logic       clk,
  input  logic       rst,
  idct_macu_if.slave bus,
  output logic [7:0] dbg_term_cnt_o,
  output logic       dbg_stall_o
);

  localparam int PROD_W = DIN_W + CW;
  localparam int CNT_W  = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NTERMS - 1);
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (FRAC - 1));
`ifdef IDCT_MACU_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (OUT_W - 1)));
`endif

  logic signed [PROD_W-1:0] mult_res_q, mult_res_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic [CNT_W-1:0]         term_cnt_q, term_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;

  logic                     stall;
  logic                     accept;
  logic                     emit;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_rnd;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  out_res;
  logic                     unused_shift_hi;

  // A finished sum may only leave stage 2 if the output register is free or
  // being drained this edge; otherwise the whole pipe freezes.
  assign stall  = s1_valid_q & s1_last_q & out_valid_q & ~bus.out_ready;
  assign accept = bus.in_valid & ~stall;
  assign emit   = s1_valid_q & s1_last_q & ~stall;

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign dbg_term_cnt_o = 8'(term_cnt_q);
  assign dbg_stall_o    = stall;

  // Final sum, round-half-up and scale of the block currently closing.
  always_comb begin
    sum     = acc_q + ACC_W'(mult_res_q);
    sum_rnd = sum + HALF_LSB;
    shifted = sum_rnd >>> FRAC;
`ifdef IDCT_MACU_SAT_EN
    if (shifted > SAT_MAX) begin
      out_res = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      out_res = SAT_MIN[OUT_W-1:0];
    end else begin
      out_res = shifted[OUT_W-1:0];
    end
`else
    out_res = shifted[OUT_W-1:0];
`endif
  end

  // Upper bits only matter to the clamp; fold them so the wrap build is tidy.
  assign unused_shift_hi = ^shifted[ACC_W-1:OUT_W];

  // Next-state for the multiplier stage, term counter, accumulator and output.
  always_comb begin
    mult_res_d  = mult_res_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    term_cnt_d  = term_cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        mult_res_d = PROD_W'(bus.in_data) * PROD_W'(bus.in_coef);
        s1_last_d  = (term_cnt_q == LAST_CNT);
        term_cnt_d = (term_cnt_q == LAST_CNT) ? '0 : term_cnt_q + CNT_W'(1);
      end
    end

    if (s1_valid_q && !s1_last_q) begin
      acc_d = sum;
    end else if (emit) begin
      acc_d = '0;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = out_res;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any partial sum and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_res_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      term_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mult_res_q  <= mult_res_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      term_cnt_q  <= term_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_idct_macu.sv
// tb_idct_macu: directed and randomised checks of idct_macu (default parameters).
// A +2048 cosine constant does not fit a 12-bit signed coef, so the unity
// block uses data=-1, coef=-2048 (product +2048, same as 1 * 2048).
module tb_idct_macu;

  typedef logic signed [11:0] term_arr_t [8];

  logic clk;
  logic rst;
  logic [7:0] dbg_term_cnt;
  logic       dbg_stall;

  int n_vec;
  int n_err;
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

  idct_macu_if #(.DIN_W(12), .CW(12), .OUT_W(12)) bus ();

  idct_macu dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .dbg_term_cnt_o (dbg_term_cnt),
    .dbg_stall_o    (dbg_stall)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  // One clock: note handshakes just before the edge, return 1 ns after it.
  task automatic step(output bit in_fire);
    bit          of;
    logic [11:0] od;
    #1;
    in_fire = bus.in_valid & bus.in_ready;
    of      = bus.out_valid & bus.out_ready;
    od      = bus.out_data;
    @(posedge clk);
    #1;
    if (of) got_q.push_back(od);
  endtask

  // Present one term and hold it until accepted; leaves in_valid high.
  task automatic send_term(input logic signed [11:0] d, input logic signed [11:0] c);
    bit f;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_coef  = c;
    for (int i = 0; i < 200; i++) begin
      step(f);
      if (f) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL send_term: in_ready=%b after 200 cycles, need 1", bus.in_ready);
  endtask

  task automatic send_block(input term_arr_t d, input term_arr_t c);
    for (int i = 0; i < 8; i++) send_term(d[i], c[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    bit f;
    for (int i = 0; i < 40 && got_q.size() < n; i++) step(f);
  endtask

  function automatic logic [11:0] ref_out(input longint s);
    longint r;
    r = (s + 64'sd1024) >>> 11;
`ifdef IDCT_MACU_SAT_EN
    if (r > 64'sd2047) r = 64'sd2047;
    else if (r < -64'sd2048) r = -64'sd2048;
`endif
    return r[11:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit f;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(f);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_data !== 12'h000) begin
      n_err++; $display("FAIL reset_out_data: got %h need 000", bus.out_data);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready);
    end
    n_vec++;
    if (dbg_term_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_term_cnt: got %0d need 0", dbg_term_cnt);
    end
  endtask

  task automatic test_unity();
    bit f;
    bus.out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 8; i++) send_term(-12'sd1, -12'sd2048);
    bus.in_valid = 1'b0;
    // Accept edge of the last term has only loaded the product register.
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL unity_early: out_valid got %b need 0", bus.out_valid);
    end
    step(f);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 12'd8) begin
      n_err++; $display("FAIL unity_result: valid/data got %b/%h need 1/008", bus.out_valid, bus.out_data);
    end
    step(f);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL unity_clear: out_valid got %b need 0", bus.out_valid);
    end
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 12'd8) begin
      n_err++; $display("FAIL unity_count: got %0d outputs need 1 (value 008)", got_q.size());
    end
  endtask

  task automatic test_rounding();
    // term0 only; remaining terms zero.  1*1024 -> 1, -1*1024 -> 0 (tie up),
    // 3*-1024 -> -1 (tie up), 1*-1024 -> 0 (tie up), 3*1024 -> 2 (tie up).
    logic signed [11:0] cd [5] = '{12'sd1, -12'sd1, 12'sd3, 12'sd1, 12'sd3};
    logic signed [11:0] cc [5] = '{12'sd1024, 12'sd1024, -12'sd1024, -12'sd1024, 12'sd1024};
    logic [11:0]        ce [5] = '{12'h001, 12'h000, 12'hFFF, 12'h000, 12'h002};
    term_arr_t d, c;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        d[i] = '0;
        c[i] = '0;
      end
      d[0] = cd[k];
      c[0] = cc[k];
      got_q.delete();
      send_block(d, c);
      wait_out(1);
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== ce[k]) begin
        n_err++;
        $display("FAIL rounding_%0d: got %0d outputs first %h need 1 output %h",
                 k, got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'hxxx, ce[k]);
      end
    end
  endtask

  task automatic test_overflow();
    term_arr_t d, c;
    logic [11:0] e_pos, e_neg;
`ifdef IDCT_MACU_SAT_EN
    e_pos = 12'h7FF;
    e_neg = 12'h800;
`else
    e_pos = 12'hFF0;  // 16368 wraps to -16
    e_neg = 12'h008;  // -16376 wraps to 8
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = 12'sd2047;
      c[i] = 12'sd2047;
    end
    got_q.delete();
    send_block(d, c);
    wait_out(1);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== e_pos) begin
      n_err++; $display("FAIL overflow_pos: got %0d outputs first %h need %h",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'hxxx, e_pos);
    end
    for (int i = 0; i < 8; i++) begin
      d[i] = -12'sd2048;
      c[i] = 12'sd2047;
    end
    got_q.delete();
    send_block(d, c);
    wait_out(1);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== e_neg) begin
      n_err++; $display("FAIL overflow_neg: got %0d outputs first %h need %h",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'hxxx, e_neg);
    end
  endtask

  task automatic test_back_to_back();
    bit f;
    bus.out_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) send_term(-12'sd1, -12'sd2048);  // -> 8
    for (int i = 0; i < 8; i++) send_term(-12'sd2, -12'sd2048);  // -> 16
    bus.in_valid = 1'b0;
    // Block 2's last product is parked in stage 1 behind the unread result.
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++; $display("FAIL b2b_stall_%0d: in_ready got %b need 0", k, bus.in_ready);
      end
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 12'd8) begin
        n_err++; $display("FAIL b2b_hold_%0d: valid/data got %b/%h need 1/008", k, bus.out_valid, bus.out_data);
      end
      step(f);
    end
    bus.out_ready = 1'b1;
    step(f);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 12'd16 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_reload: valid/data/ready got %b/%h/%b need 1/010/1",
                        bus.out_valid, bus.out_data, bus.in_ready);
    end
    step(f);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: out_valid got %b need 0", bus.out_valid);
    end
    n_vec++;
    if (got_q.size() != 2 || got_q[0] !== 12'd8 || got_q[1] !== 12'd16) begin
      n_err++; $display("FAIL b2b_order: got %0d outputs need 2 (008 then 010)", got_q.size());
    end
    n_vec++;
    if (dbg_term_cnt !== 8'd0) begin
      n_err++; $display("FAIL b2b_term_cnt: got %0d need 0", dbg_term_cnt);
    end
  endtask

  task automatic test_reset_mid_block();
    bit f;
    term_arr_t d, c;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_term(12'sd500, 12'sd1500);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step(f);
    rst = 1'b0;
    n_vec++;
    if (dbg_term_cnt !== 8'd0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: term_cnt/out_valid got %0d/%b need 0/0", dbg_term_cnt, bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      d[i] = -12'sd1;
      c[i] = -12'sd2048;
    end
    got_q.delete();
    send_block(d, c);
    wait_out(1);
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 12'd8) begin
      n_err++; $display("FAIL midrst_result: got %0d outputs first %h need 1 output 008",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'hxxx);
    end
  endtask

  task automatic test_random();
    bit     f;
    int     blocks;
    int     terms;
    int     cyc;
    longint acc;
    blocks = 0;
    terms  = 0;
    cyc    = 0;
    acc    = 0;
    got_q.delete();
    exp_q.delete();
    bus.in_valid = 1'b0;
    while (blocks < 1000 && cyc < 60000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 12'($urandom_range(0, 4095));
        bus.in_coef  = 12'($urandom_range(0, 4095));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(f);
      cyc++;
      if (f) begin
        acc = acc + longint'(bus.in_data) * longint'(bus.in_coef);
        terms++;
        if (terms == 8) begin
          exp_q.push_back(ref_out(acc));
          acc   = 0;
          terms = 0;
          blocks++;
        end
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && got_q.size() < exp_q.size(); i++) step(f);
    n_vec++;
    if (blocks != 1000 || got_q.size() != 1000 || exp_q.size() != 1000) begin
      n_err++; $display("FAIL random_count: blocks/outputs/expected got %0d/%0d/%0d need 1000/1000/1000",
                        blocks, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL random_block_%0d: got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_unity();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
